// File: rtl/level_gen_pkg.sv
// Shared types for the level generator: FSM state enum and its 2-bit encoding.
package level_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    GAP  = ST_GAP
  } lg_state_t;

endpackage

// File: rtl/level_generator_hold_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases of level_generator.
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/level_generator.sv
// Tick-to-level converter with programmable high time and enforced low gap.
// Optional feature: define LEVEL_GEN_RETRIGGER_EN to let ticks in HIGH extend the pulse.
module level_generator
  import level_gen_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MIN_LOW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] hold_len,
  output logic             level,
  output logic             busy,
  output logic             dropped
);

`ifdef LEVEL_GEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);

  lg_state_t        state;
  logic             load;
  logic             dec;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] hold_eff;
  logic [CNT_W-1:0] cnt;
  logic             is_one;
  logic             retrigger;
  logic             drop_now;

  // A requested length of zero still produces a one-cycle pulse.
  assign hold_eff  = (hold_len == '0) ? CNT_W'(1) : hold_len;
  assign retrigger = RETRIG && tick && (state == HIGH);
  assign drop_now  = tick && (state != IDLE) && !retrigger;

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    load     = 1'b0;
    dec      = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          load     = 1'b1;
          load_val = hold_eff;
        end
      end
      HIGH: begin
        if (retrigger) begin
          load     = 1'b1;
          load_val = hold_eff;
        end else if (is_one) begin
          load     = (MIN_LOW > 0);
          load_val = MIN_LOW_C;
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        dec = !is_one;
      end
      default: ;
    endcase
  end

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .is_one   (is_one)
  );

  // Outputs are registered alongside the state so they are glitch-free copies of its decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      level   <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_now;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state <= HIGH;
            level <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (!retrigger && is_one) begin
            level <= 1'b0;
            if (MIN_LOW > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (is_one) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          level <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_generator.sv
// Directed self-checking bench for level_generator (MIN_LOW=2 and MIN_LOW=0 instances).
module tb_level_generator;

  localparam int CNT_W = 8;

`ifdef LEVEL_GEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tick = 1'b0;
  logic [CNT_W-1:0] hold_len = '0;
  logic             level, busy, dropped;
  logic             level0, busy0, dropped0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  level_generator #(.CNT_W(CNT_W), .MIN_LOW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .hold_len (hold_len),
    .level    (level),
    .busy     (busy),
    .dropped  (dropped)
  );

  level_generator #(.CNT_W(CNT_W), .MIN_LOW(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .hold_len (hold_len),
    .level    (level0),
    .busy     (busy0),
    .dropped  (dropped0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick  = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    // Reset state.
    do_reset();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);

    // hold_len=3, MIN_LOW=2: three high cycles, two gap cycles, then idle.
    begin
      logic [5:0] exp_lvl;
      logic [5:0] exp_busy;
      exp_lvl  = 6'b000111;
      exp_busy = 6'b011111;
      hold_len = 8'd3;
      tick     = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        tick = 1'b0;
        check($sformatf("h3_level[%0d]", i), level, exp_lvl[i]);
        check($sformatf("h3_busy[%0d]", i), busy, exp_busy[i]);
      end
      check("h3_dropped", dropped, 0);
    end

    // hold_len=0 is treated as 1.
    begin
      logic [3:0] exp_lvl;
      logic [3:0] exp_busy;
      exp_lvl  = 4'b0001;
      exp_busy = 4'b0111;
      hold_len = 8'd0;
      tick     = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        tick = 1'b0;
        check($sformatf("h0_level[%0d]", i), level, exp_lvl[i]);
        check($sformatf("h0_busy[%0d]", i), busy, exp_busy[i]);
      end
    end

    if (!RETRIG) begin
      // Tick one edge after acceptance and on the last GAP cycle: both dropped.
      logic [6:0] tick_v, exp_lvl, exp_busy, exp_drop;
      tick_v   = 7'b0010011;
      exp_lvl  = 7'b0000111;
      exp_busy = 7'b0011111;
      exp_drop = 7'b0010010;
      hold_len = 8'd3;
      for (int i = 0; i < 7; i++) begin
        tick = tick_v[i];
        step();
        check($sformatf("drop_level[%0d]", i), level, exp_lvl[i]);
        check($sformatf("drop_busy[%0d]", i), busy, exp_busy[i]);
        check($sformatf("drop_dropped[%0d]", i), dropped, exp_drop[i]);
      end
      tick = 1'b0;
    end else begin
      // Retrigger on HIGH cycle 3 with hold_len=4: 3+4 = 7 high cycles, no drops.
      logic [8:0] tick_v, exp_lvl;
      tick_v   = 9'b000001001;
      exp_lvl  = 9'b001111111;
      hold_len = 8'd4;
      for (int i = 0; i < 9; i++) begin
        tick = tick_v[i];
        step();
        check($sformatf("retrig_level[%0d]", i), level, exp_lvl[i]);
        check($sformatf("retrig_dropped[%0d]", i), dropped, 0);
      end
      tick = 1'b0;
      repeat (3) step();
      check("retrig_idle", busy, 0);
    end

    // Asynchronous reset on HIGH cycle 2 of a hold_len=10 pulse.
    hold_len = 8'd10;
    tick     = 1'b1;
    step();
    step();
    tick = 1'b0;
    check("pre_rst_level", level, 1);
    check("pre_rst_dropped", dropped, !RETRIG);
    #2;
    reset = 1'b0;
    #1;
    check("async_level", level, 0);
    check("async_busy", busy, 0);
    check("async_dropped", dropped, 0);
    tick = 1'b1;
    step();
    check("rst_held_busy", busy, 0);
    tick  = 1'b0;
    reset = 1'b1;
    step();
    tick = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      tick = 1'b0;
      check($sformatf("fresh_level[%0d]", i), level, (i < 10) ? 1 : 0);
    end
    repeat (3) step();

    // MIN_LOW=0, tick held high, hold_len=2.
    do_reset();
    begin
      logic [5:0] exp_lvl, exp_drop;
      exp_lvl  = RETRIG ? 6'b111111 : 6'b011011;
      exp_drop = RETRIG ? 6'b000000 : 6'b110110;
      hold_len = 8'd2;
      tick     = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        check($sformatf("ml0_level[%0d]", i), level0, exp_lvl[i]);
        check($sformatf("ml0_dropped[%0d]", i), dropped0, exp_drop[i]);
      end
      tick = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
